display_varredura: RTL
======================

# display_varredura

Multiplexed multi-digit seven-segment driver with per-digit even-parity checking, the parametrised successor of the single-digit combinational display decoder. It registers a bank of DIGITOS values plus parity bits on a load strobe, scans them onto one shared segment bus with one-hot active-low digit enables, and reports live and sticky validity. It sits between the datapath result registers and the board's display pins.

## Interface
- DIGITOS, 4: number of digits scanned (≥2).
- LARGURA, 5: bits per digit value (≥4).
- DIV, 1000: clock cycles per digit slot (≥2).
- Clock  in  1  single system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Carregar  in  1  load strobe; captures Valores/Paridade on the edge where high.
- Valores  in  DIGITOS*LARGURA  digit i occupies bits [i*LARGURA +: LARGURA].
- Paridade  in  DIGITOS  parity bit of digit i.
- Limpar  in  1  clears sticky error flags.
- Segmentos  out  7  active-high segments, bit order {g,f,e,d,c,b,a}.
- Anodos  out  DIGITOS  one-hot active-low digit enable.
- Validade  out  1  high when every stored digit passes parity.
- Erros  out  DIGITOS  sticky per-digit parity-error flags.

## Operation
- Reset: stored values 0, stored parity 0, Segmentos 7'b0000000, Anodos all 1s, Validade 1, Erros 0, scan index 0, prescaler 0.
- Load: Carregar high captures all digits simultaneously; no partial update.
- Parity: digit i valid iff XOR over {value_i, parity_i} == 0 (even). Validade = AND of all digit-valid bits, computed from stored registers.
- Sticky errors: Erros[i] sets on the load that stores an invalid digit i; cleared only by Limpar or reset. Limpar and a setting load in the same cycle: set wins.
- Glyph per scanned digit: invalid parity → "E" 7'b1111001; value ≥16 → dash 7'b1000000; else hex 0–F (0 = 7'b0111111, 1 = 7'b0000110, 2 = 7'b1011011, 8 = 7'b1111111, A = 7'b1110111, F = 7'b1110001).
- Scan: prescaler counts 0..DIV-1 and wraps; on wrap, index advances, DIGITOS-1 → 0.
- Anti-ghosting: during prescaler count 0 of each slot, Anodos all 1s and Segmentos 0; counts 1..DIV-1 drive Anodos[index]=0 with that digit's glyph.

## Timing
- Segmentos, Anodos, Validade, Erros are all registered; no combinational input-to-output path.
- Validade and Erros reflect a load one cycle after the Carregar edge.
- A digit's glyph change appears at the next non-blank cycle of its slot (≤ DIGITOS*DIV cycles after load).
- Load mid-slot: current slot continues with new data from the following cycle; scan timing is not disturbed.
- Reset asserted mid-scan: outputs return to reset values immediately (async); scan restarts at index 0, count 0 after release.
- Full scan period DIGITOS*DIV cycles; each digit lit DIV-1 of every DIGITOS*DIV cycles.

## Structure
- Package display_pkg: 7-bit glyph constants (hex 0–F, GLIFO_TRACO, GLIFO_ERRO), segment bit-order constants, function paridade_ok.
- Sub-module decod_7seg: combinational {value, valid} → glyph, shared across digits (one instance after the scan mux).
- Top holds data/parity registers, prescaler, scan index, sticky flags and output registers.

## Test plan
- Reset with DIGITOS=4, DIV=4: Anodos=4'b1111, Segmentos=0, Validade=1, Erros=0 until first non-blank cycle.
- Load digits {3:0}= 0,1,2,8 with parity 0,1,1,1 → Validade=1; over 16 cycles Anodos cycles 1110,1101,1011,0111 with glyphs 0111111,0000110,1011011,1111111; blank at count 0 each slot.
- Load digit 2 = 5'b00010 with parity 0 → Validade=0, Erros=4'b0100, digit-2 slot shows 1111001; reload valid → Validade=1, Erros still 4'b0100; Limpar → Erros=0.
- Load digit 0 = 5'b10011, parity 1 → digit-0 slot shows dash 1000000, Validade=1.
- Limpar and invalid load same cycle → Erros bit set.
- Reset_n pulsed mid-slot at index 2 → immediate reset outputs; after release scan resumes at index 0, Anodos 1110 on cycle 1.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants for the seven-segment scan driver.
//   - Segment bit positions inside a 7-bit glyph {g,f,e,d,c,b,a}.
//   - Active-high glyph table for hex 0-F, plus dash (out of range) and "E" (parity error).
//   - paridade_ok: even-parity check over {value, parity bit}.
package display_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] GLIFO_APAGADO = 7'b0000000;
    localparam logic [6:0] GLIFO_TRACO   = 7'b1000000;
    localparam logic [6:0] GLIFO_ERRO    = 7'b1111001;

    localparam logic [6:0] GLIFOS_HEX [16] = '{
        7'b0111111, // 0
        7'b0000110, // 1
        7'b1011011, // 2
        7'b1001111, // 3
        7'b1100110, // 4
        7'b1101101, // 5
        7'b1111101, // 6
        7'b0000111, // 7
        7'b1111111, // 8
        7'b1101111, // 9
        7'b1110111, // A
        7'b1111100, // b
        7'b0111001, // C
        7'b1011110, // d
        7'b1111001, // E
        7'b1110001  // F
    };

    // Callers zero-extend the value to 32 bits; extra zeros do not change the XOR.
    function automatic logic paridade_ok(input logic [31:0] valor, input logic paridade);
        return ~(^{valor, paridade});
    endfunction

endpackage

// File: rtl/display_varredura_if.sv
// display_varredura_if: datapath-side bus of the multiplexed display driver.
//   master: drives Carregar, Valores, Paridade, Limpar; reads display outputs.
//   slave : the driver itself; receives load/clear, drives Segmentos, Anodos,
//           Validade, Erros.
interface display_varredura_if #(
    parameter int DIGITOS = 4,
    parameter int LARGURA = 5
);
    logic                         Carregar;
    logic [DIGITOS*LARGURA-1:0]   Valores;
    logic [DIGITOS-1:0]           Paridade;
    logic                         Limpar;
    logic [6:0]                   Segmentos;
    logic [DIGITOS-1:0]           Anodos;
    logic                         Validade;
    logic [DIGITOS-1:0]           Erros;

    modport master (
        output Carregar, Valores, Paridade, Limpar,
        input  Segmentos, Anodos, Validade, Erros
    );

    modport slave (
        input  Carregar, Valores, Paridade, Limpar,
        output Segmentos, Anodos, Validade, Erros
    );

endinterface

// File: rtl/decod_7seg.sv
// decod_7seg: combinational glyph decoder for one digit.
//   valor  in  LARGURA  digit value
//   valido in  1        digit passed its parity check
//   glifo  out 7        active-high segments {g,f,e,d,c,b,a}
// Priority: parity error shows "E", then values >= 16 show a dash, else hex.
module decod_7seg
    import display_pkg::*;
#(
    parameter int LARGURA = 5
) (
    input  logic [LARGURA-1:0] valor,
    input  logic               valido,
    output logic [6:0]         glifo
);

    always_comb begin
        glifo = GLIFO_APAGADO;
        if (!valido) begin
            glifo = GLIFO_ERRO;
        end else if (int'(valor) >= 16) begin
            glifo = GLIFO_TRACO;
        end else begin
            glifo = GLIFOS_HEX[valor[3:0]];
        end
    end

endmodule

// File: rtl/display_varredura.sv
// display_varredura: multiplexed multi-digit seven-segment driver with parity checking.
//   Clock    in  1   system clock, rising edge
//   Reset_n  in  1   asynchronous active-low reset
//   bus      slave modport of display_varredura_if:
//     Carregar/Valores/Paridade  load strobe and digit bank captured together
//     Limpar                     clears sticky error flags (a same-cycle setting load wins)
//     Segmentos                  glyph of the scanned digit, 0 during blank
//     Anodos                     one-hot active-low digit enable, all 1s during blank
//     Validade                   every stored digit passes even parity
//     Erros                      sticky per-digit parity-error flags
// Each slot lasts DIV cycles; the first cycle of every slot is blanked to avoid ghosting.
module display_varredura
    import display_pkg::*;
#(
    parameter int DIGITOS = 4,
    parameter int LARGURA = 5,
    parameter int DIV     = 1000
) (
    input  logic Clock,
    input  logic Reset_n,
    display_varredura_if.slave bus
);

    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [LARGURA-1:0] valores_q [DIGITOS];
    logic [LARGURA-1:0] valores_d [DIGITOS];
    logic [DIGITOS-1:0] paridade_q, paridade_d;
    logic [DIGITOS-1:0] validos_d;
    logic [DIGITOS-1:0] erros_q, erros_d;
    logic               validade_q, validade_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [6:0]         segmentos_q, segmentos_d;
    logic [DIGITOS-1:0] anodos_q, anodos_d;

    logic [LARGURA-1:0] valor_sel;
    logic               valido_sel;
    logic [6:0]         glifo_sel;

    // Data path: the whole bank is replaced at once on a load.
    always_comb begin
        paridade_d = bus.Carregar ? bus.Paridade : paridade_q;
        for (int i = 0; i < DIGITOS; i++) begin
            valores_d[i] = bus.Carregar ? bus.Valores[i*LARGURA +: LARGURA] : valores_q[i];
            validos_d[i] = paridade_ok(32'(valores_d[i]), paridade_d[i]);
        end
        validade_d = &validos_d;
        erros_d    = (bus.Limpar ? '0 : erros_q) | (bus.Carregar ? ~validos_d : '0);
    end

    // Scan timing: prescaler wraps at DIV-1 and steps the digit index.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITOS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with cnt_q/idx_q
    // and show freshly loaded data on the cycle right after the load.
    always_comb begin
        valor_sel  = valores_d[idx_d];
        valido_sel = validos_d[idx_d];
    end

    decod_7seg #(
        .LARGURA (LARGURA)
    ) u_decod (
        .valor  (valor_sel),
        .valido (valido_sel),
        .glifo  (glifo_sel)
    );

    always_comb begin
        anodos_d    = '1;
        segmentos_d = GLIFO_APAGADO;
        if (cnt_d != '0) begin
            anodos_d    = ~(DIGITOS'(1) << idx_d);
            segmentos_d = glifo_sel;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DIGITOS; i++) begin
                valores_q[i] <= '0;
            end
            paridade_q  <= '0;
            erros_q     <= '0;
            validade_q  <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            segmentos_q <= GLIFO_APAGADO;
            anodos_q    <= '1;
        end else begin
            for (int i = 0; i < DIGITOS; i++) begin
                valores_q[i] <= valores_d[i];
            end
            paridade_q  <= paridade_d;
            erros_q     <= erros_d;
            validade_q  <= validade_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            segmentos_q <= segmentos_d;
            anodos_q    <= anodos_d;
        end
    end

    assign bus.Segmentos = segmentos_q;
    assign bus.Anodos    = anodos_q;
    assign bus.Validade  = validade_q;
    assign bus.Erros     = erros_q;

endmodule
